// File: rtl/safe_region_if.sv
// Operation bus for safe_region: one op per cycle in, registered result out.
interface safe_region_if;
  logic        enop;
  logic [7:0]  op;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output enop, op, wdata, input rdata);
  modport slave  (input enop, op, wdata, output rdata);
endinterface

// File: rtl/safe_region.sv
// Protected-region table: NREGIONS start/end/perm entries, programmed and read
// through a select register, with a single-cycle parallel address check.
module safe_region #(
  parameter int NREGIONS = 8
) (
  input  logic          clk,
  input  logic          reset,
  safe_region_if.slave  bus
);
  localparam int SEL_W = (NREGIONS > 1) ? $clog2(NREGIONS) : 1;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_SEL    = 8'h01;
  localparam logic [7:0] OP_WSTART = 8'h02;
  localparam logic [7:0] OP_WEND   = 8'h03;
  localparam logic [7:0] OP_WPERM  = 8'h04;
  localparam logic [7:0] OP_CHECK  = 8'h05;
  localparam logic [7:0] OP_RSTART = 8'h10;
  localparam logic [7:0] OP_REND   = 8'h11;
  localparam logic [7:0] OP_RPERM  = 8'h12;
  localparam logic [7:0] OP_RSEL   = 8'h13;

  logic [31:0]      start_q [NREGIONS];
  logic [31:0]      end_q   [NREGIONS];
  logic [2:0]       perm_q  [NREGIONS];
  logic [NREGIONS-1:0] valid_q;
  logic [SEL_W-1:0] sel_q;
  logic [31:0]      rdata_p1;

  logic [NREGIONS-1:0] hit_vec;
  logic                hit_any;
  logic [SEL_W-1:0]    hit_idx;
  logic [31:0]         check_res;

  function automatic logic [31:0] pack_check(input logic hit,
                                             input logic [SEL_W-1:0] idx,
                                             input logic [2:0] perm);
    logic [31:0] res;
    res = 32'h0;
    if (hit) begin
      res[31]  = 1'b1;
      res[6:4] = 3'(idx);
      res[2:0] = perm;
    end
    return res;
  endfunction

  // Parallel compare of every entry; an empty range (start >= end) can never
  // satisfy start <= addr < end, so no separate guard is needed.
  always_comb begin
    for (int i = 0; i < NREGIONS; i++) begin
      hit_vec[i] = valid_q[i] && (bus.wdata >= start_q[i]) && (bus.wdata < end_q[i]);
    end
  end

  // Priority encoder: scanning downward lets the lowest hit index win.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = NREGIONS - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        hit_any = 1'b1;
        hit_idx = SEL_W'(i);
      end
    end
  end

  assign check_res = pack_check(hit_any, hit_idx, perm_q[hit_idx]);

  // Stage p1: op executes and its result is registered into rdata.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGIONS; i++) begin
        start_q[i] <= 32'h0;
        end_q[i]   <= 32'h0;
        perm_q[i]  <= 3'h0;
      end
      valid_q  <= '0;
      sel_q    <= '0;
      rdata_p1 <= 32'h0;
    end else if (bus.enop) begin
      case (bus.op)
        OP_NOP: ;
        OP_SEL: begin
          sel_q    <= bus.wdata[SEL_W-1:0];
          rdata_p1 <= 32'h0;
        end
        OP_WSTART: begin
          start_q[sel_q] <= bus.wdata;
          rdata_p1       <= 32'h0;
        end
        OP_WEND: begin
          end_q[sel_q] <= bus.wdata;
          rdata_p1     <= 32'h0;
        end
        OP_WPERM: begin
          perm_q[sel_q]  <= bus.wdata[2:0];
          valid_q[sel_q] <= bus.wdata[31];
          rdata_p1       <= 32'h0;
        end
        OP_CHECK:  rdata_p1 <= check_res;
        OP_RSTART: rdata_p1 <= start_q[sel_q];
        OP_REND:   rdata_p1 <= end_q[sel_q];
        OP_RPERM:  rdata_p1 <= {valid_q[sel_q], 28'h0, perm_q[sel_q]};
        OP_RSEL:   rdata_p1 <= 32'(sel_q);
        default:   rdata_p1 <= 32'hFFFF_FFFF;
      endcase
    end
  end

  assign bus.rdata = rdata_p1;

endmodule

// File: tb/tb_safe_region.sv
// Self-checking bench for safe_region: expected rdata is queued when an op is
// driven and compared once the registered result appears.
module tb_safe_region;
  logic clk = 1'b0;
  logic reset;
  safe_region_if bus();

  safe_region #(.NREGIONS(8)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_v;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] wd;
    logic [31:0] exp;
  } step_t;

  // Present one op for exactly one rising edge, then release enop.
  task automatic drive_op(input logic [7:0] op, input logic [31:0] wd);
    @(negedge clk);
    bus.enop  = 1'b1;
    bus.op    = op;
    bus.wdata = wd;
    @(posedge clk);
    #1;
    bus.enop = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.enop = 1'b0; bus.op = 8'h0; bus.wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata got=%h exp=%h", bus.rdata, 32'h0);
    end
    @(negedge clk);
    reset = 1'b0;
    sb.push_back(32'h0);
    drive_op(8'h05, 32'h0000_0100);
    exp_v = sb.pop_front();
    checks++;
    if (bus.rdata !== exp_v) begin
      errors++; $display("FAIL reset_check got=%h exp=%h", bus.rdata, exp_v);
    end
  endtask

  task automatic test_config();
    step_t t[$] = '{
      '{8'h01, 32'h2,          32'h0},
      '{8'h02, 32'h1000,       32'h0},
      '{8'h03, 32'h2000,       32'h0},
      '{8'h04, 32'h8000_0003,  32'h0},
      '{8'h05, 32'h1000,       32'h8000_0023},
      '{8'h05, 32'h1FFF,       32'h8000_0023},
      '{8'h05, 32'h2000,       32'h0},
      '{8'h05, 32'h0FFF,       32'h0}
    };
    foreach (t[i]) begin
      sb.push_back(t[i].exp);
      drive_op(t[i].op, t[i].wd);
      exp_v = sb.pop_front();
      checks++;
      if (bus.rdata !== exp_v) begin
        errors++; $display("FAIL config[%0d] op=%h got=%h exp=%h", i, t[i].op, bus.rdata, exp_v);
      end
    end
  endtask

  task automatic test_overlap();
    step_t t[$] = '{
      '{8'h01, 32'h1,          32'h0},
      '{8'h02, 32'h0,          32'h0},
      '{8'h03, 32'h4000,       32'h0},
      '{8'h04, 32'h8000_0004,  32'h0},
      '{8'h05, 32'h1800,       32'h8000_0014},
      '{8'h05, 32'h3000,       32'h8000_0014},
      '{8'h05, 32'h4000,       32'h0}
    };
    foreach (t[i]) begin
      sb.push_back(t[i].exp);
      drive_op(t[i].op, t[i].wd);
      exp_v = sb.pop_front();
      checks++;
      if (bus.rdata !== exp_v) begin
        errors++; $display("FAIL overlap[%0d] op=%h got=%h exp=%h", i, t[i].op, bus.rdata, exp_v);
      end
    end
  endtask

  task automatic test_readback();
    step_t t[$] = '{
      '{8'h01, 32'h2,  32'h0},
      '{8'h10, 32'h0,  32'h0000_1000},
      '{8'h11, 32'h0,  32'h0000_2000},
      '{8'h12, 32'h0,  32'h8000_0003},
      '{8'h13, 32'h0,  32'h0000_0002},
      '{8'h7F, 32'h0,  32'hFFFF_FFFF},
      '{8'h10, 32'h0,  32'h0000_1000},
      '{8'h01, 32'hA,  32'h0},
      '{8'h13, 32'h0,  32'h0000_0002}
    };
    foreach (t[i]) begin
      sb.push_back(t[i].exp);
      drive_op(t[i].op, t[i].wd);
      exp_v = sb.pop_front();
      checks++;
      if (bus.rdata !== exp_v) begin
        errors++; $display("FAIL readback[%0d] op=%h got=%h exp=%h", i, t[i].op, bus.rdata, exp_v);
      end
    end
  endtask

  // Writes followed immediately by a dependent check, plus boundary entries.
  task automatic test_back_to_back();
    step_t t[$] = '{
      '{8'h01, 32'h3,          32'h0},
      '{8'h02, 32'h8000,       32'h0},
      '{8'h03, 32'h9000,       32'h0},
      '{8'h04, 32'h8000_0005,  32'h0},
      '{8'h05, 32'h8800,       32'h8000_0035},
      '{8'h01, 32'h4,          32'h0},
      '{8'h02, 32'h5000,       32'h0},
      '{8'h03, 32'h5000,       32'h0},
      '{8'h04, 32'h8000_0007,  32'h0},
      '{8'h05, 32'h5000,       32'h0},
      '{8'h01, 32'h5,          32'h0},
      '{8'h02, 32'h0,          32'h0},
      '{8'h03, 32'hFFFF_FFFF,  32'h0},
      '{8'h04, 32'h8000_0001,  32'h0},
      '{8'h05, 32'hFFFF_FFFE,  32'h8000_0051},
      '{8'h05, 32'hFFFF_FFFF,  32'h0},
      '{8'h04, 32'h0000_0007,  32'h0},
      '{8'h05, 32'hFFFF_FFFE,  32'h0},
      '{8'h12, 32'h0,          32'h0000_0007}
    };
    foreach (t[i]) begin
      sb.push_back(t[i].exp);
      drive_op(t[i].op, t[i].wd);
      exp_v = sb.pop_front();
      checks++;
      if (bus.rdata !== exp_v) begin
        errors++; $display("FAIL b2b[%0d] op=%h got=%h exp=%h", i, t[i].op, bus.rdata, exp_v);
      end
    end
  endtask

  task automatic test_hold_reset();
    sb.push_back(32'h0);
    drive_op(8'h01, 32'h2);
    exp_v = sb.pop_front();
    checks++;
    if (bus.rdata !== exp_v) begin
      errors++; $display("FAIL hold_sel got=%h exp=%h", bus.rdata, exp_v);
    end
    sb.push_back(32'h0000_1000);
    drive_op(8'h10, 32'h0);
    exp_v = sb.pop_front();
    checks++;
    if (bus.rdata !== exp_v) begin
      errors++; $display("FAIL hold_rstart got=%h exp=%h", bus.rdata, exp_v);
    end
    // Garbage on op/wdata while enop is low must be ignored.
    bus.op = 8'h7F; bus.wdata = 32'hDEAD_BEEF;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.rdata !== 32'h0000_1000) begin
        errors++; $display("FAIL hold_cycle%0d got=%h exp=%h", c, bus.rdata, 32'h0000_1000);
      end
    end
    // Reset between edges, with a write presented on the same cycle.
    @(negedge clk);
    bus.enop = 1'b1; bus.op = 8'h02; bus.wdata = 32'hDEAD_0000;
    #1 reset = 1'b1;
    #1;
    checks++;
    if (bus.rdata !== 32'h0) begin
      errors++; $display("FAIL async_reset got=%h exp=%h", bus.rdata, 32'h0);
    end
    @(posedge clk); #1;
    bus.enop = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    sb.push_back(32'h0);
    drive_op(8'h12, 32'h0);
    exp_v = sb.pop_front();
    checks++;
    if (bus.rdata !== exp_v) begin
      errors++; $display("FAIL post_reset_rperm got=%h exp=%h", bus.rdata, exp_v);
    end
    sb.push_back(32'h0);
    drive_op(8'h10, 32'h0);
    exp_v = sb.pop_front();
    checks++;
    if (bus.rdata !== exp_v) begin
      errors++; $display("FAIL post_reset_rstart got=%h exp=%h", bus.rdata, exp_v);
    end
    sb.push_back(32'h0);
    drive_op(8'h05, 32'h1000);
    exp_v = sb.pop_front();
    checks++;
    if (bus.rdata !== exp_v) begin
      errors++; $display("FAIL post_reset_check got=%h exp=%h", bus.rdata, exp_v);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_config();
    test_overlap();
    test_readback();
    test_back_to_back();
    test_hold_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
